// File: rtl/pipeline_controller.sv
// Run-control and hazard sequencer for the 5-stage MIPS pipeline:
// start/stall/flush gating, halt drain, memory dump stepping.
module pipeline_controller #(
  parameter logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned MEM_WORDS    = 512
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic [31:0] instr_F,
  input  logic [4:0]  Rs_D,
  input  logic [4:0]  Rt_D,
  input  logic [4:0]  Rt_E,
  input  logic        MemtoReg_E,
  input  logic        RegWrite_E,
  input  logic        branch_taken_M,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        dump_en,
  output logic [31:0] dump_addr,
  output logic        running,
  output logic        done,
  output logic [31:0] cycle_count
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [31:0] LAST_ADDR = 32'(MEM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DUMP, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] drain_q, drain_d;
  logic [31:0] dump_addr_q, dump_addr_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic        loaduse;

  assign loaduse = MemtoReg_E & RegWrite_E & (Rt_E != 5'd0)
                 & ((Rt_E == Rs_D) | (Rt_E == Rt_D));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      drain_q       <= '0;
      dump_addr_q   <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      dump_addr_q   <= dump_addr_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    dump_addr_d   = dump_addr_q;
    cycle_count_d = cycle_count_q;
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    dump_en       = 1'b0;
    done          = 1'b0;

    if ((state_q == S_RUN || state_q == S_DRAIN)
        && cycle_count_q != 32'hFFFF_FFFF)
      cycle_count_d = cycle_count_q + 32'd1;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_RUN;
          cycle_count_d = '0;
        end
      end
      S_RUN: begin
        pc_en    = 1'b1;
        if_id_en = 1'b1;
        if (branch_taken_M) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
        end else if (loaduse) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end else if (instr_F == HALT_INSTR) begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          state_d     = S_DRAIN;
          drain_d     = CW'(DRAIN_CYCLES);
        end
      end
      S_DRAIN: begin
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        drain_d     = drain_q - CW'(1);
        // A taken branch here means the halt was fetched on the wrong path
        if (branch_taken_M) begin
          pc_en        = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          state_d      = S_RUN;
        end else if (drain_q == CW'(1)) begin
          state_d     = S_DUMP;
          dump_addr_d = '0;
        end
      end
      S_DUMP: begin
        dump_en = 1'b1;
        if (dump_addr_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          dump_addr_d = dump_addr_q + 32'd1;
        end
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign running     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign dump_addr   = dump_addr_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Run-control and hazard sequencer for the 5-stage MIPS pipeline. Starts execution on request and gates PC/IF_ID updates. Inserts load-use bubbles and flushes wrong-path instructions on taken branches resolved in MEM. On fetching the halt word it drains the pipeline, then steps a dump address across MainMemory and flags completion. It sits beside the pipeline registers and drives their enable and flush controls.

## Interface
- HALT_INSTR, 32'hFFFF_FFFF, fetched word that ends the run
- DRAIN_CYCLES, 4, cycles spent emptying ID..WB after halt; must be ≥ 1
- MEM_WORDS, 512, words dumped from MainMemory; must be ≥ 1
- CLK  in  1  pipeline clock, rising edge
- RESET  in  1  asynchronous, active-high; forces IDLE
- start  in  1  begin run; sampled in IDLE only
- instr_F  in  32  word currently fetched
- Rs_D, Rt_D  in  5  source registers of instruction in ID
- Rt_E  in  5  destination of instruction in EX
- MemtoReg_E, RegWrite_E  in  1  EX is a load that writes back
- branch_taken_M  in  1  Zero_M & Branch_M
- pc_en  out  1  WB_IF register loads next PC
- if_id_en  out  1  IF_ID register loads
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  load bubble (all zeros) into that register
- dump_en  out  1  dump_addr valid this cycle
- dump_addr  out  32  word index being dumped
- running  out  1  state is RUN or DRAIN
- done  out  1  dump finished
- cycle_count  out  32  cycles spent in RUN+DRAIN

## Operation
- States are IDLE, RUN, DRAIN, DUMP and DONE. State, the drain counter, dump_addr and cycle_count are registered. All control outputs are combinational from state and inputs.
- Reset values: state=IDLE, dump_addr=0, cycle_count=0, drain counter=0. All outputs are 0 in IDLE.
- **IDLE**
  - pc_en=0, if_id_en=0.
  - start=1 → RUN, and cycle_count is cleared to 0.
- **RUN**
  - Default outputs: pc_en=1, if_id_en=1, no flush.
  - loaduse = MemtoReg_E & RegWrite_E & (Rt_E≠0) & (Rt_E==Rs_D | Rt_E==Rt_D).
  - Priority 1, branch_taken_M=1: if_id_flush=id_ex_flush=ex_mem_flush=1, pc_en=1. The halt word is ignored this cycle. Any coincident loaduse is ignored.
  - Priority 2, loaduse=1: pc_en=0, if_id_en=0, id_ex_flush=1. The halt word is ignored this cycle because it will be refetched.
  - Priority 3, instr_F==HALT_INSTR: pc_en=0, if_id_flush=1. Next state is DRAIN, and the drain counter loads DRAIN_CYCLES.
- **DRAIN**
  - pc_en=0, if_id_flush=1.
  - The counter decrements each cycle.
  - branch_taken_M=1 means the halt was on the wrong path. All three flushes are asserted, pc_en=1, and the next state is RUN. This has priority over the counter expiring.
  - Counter reaching 1 with no branch → DUMP, with dump_addr=0.
  - Load-use stalls are not generated in DRAIN.
- **DUMP**
  - dump_en=1; pc_en=0, if_id_en=0.
  - dump_addr increments by 1 each cycle.
  - At dump_addr==MEM_WORDS-1 → DONE.
- **DONE**
  - done=1; all other control outputs are 0.
  - dump_addr holds MEM_WORDS-1.
  - start is ignored; only RESET leaves DONE.
- cycle_count increments every cycle in RUN or DRAIN, saturates at 32'hFFFF_FFFF, and holds in the other states.
- RESET asserted mid-run or mid-dump returns immediately (asynchronously) to IDLE and clears all registers. No partial dump continues.

## Timing
- Latencies:
  - start high at edge t → RUN from t; first pc_en=1 in cycle t..t+1.
  - Halt fetched in cycle c (RUN) → DRAIN for cycles c+1 .. c+DRAIN_CYCLES.
  - DUMP runs for MEM_WORDS cycles, then done=1 on the following cycle.
- Halt-to-done latency is DRAIN_CYCLES + MEM_WORDS + 1 cycles. cycle_count includes the halt cycle.
- A load-use stall lasts exactly one cycle per hazard.
- A branch flush takes effect at the same edge the target PC loads.

## Test plan
- Reset then start, with program `addi $1,$0,5` followed by halt.
  - Required: RUN for 2 cycles, DRAIN for 4, then dump_en for 512 cycles with addresses 0..511.
  - done=1 on cycle 519 after start; cycle_count=6.
- Load-use: `lw $2,0($0)` followed by `add $3,$2,$2`.
  - Required: exactly one cycle with pc_en=0, if_id_en=0, id_ex_flush=1.
  - Same program with Rt_E=0 (`lw $0`): no stall.
- Taken beq two instructions before the halt word.
  - Required: halt enters DRAIN, branch_taken_M arrives in DRAIN, all three flushes pulse, state returns to RUN, and execution continues at the target.
- branch_taken_M and loaduse together, and branch_taken_M together with instr_F==HALT_INSTR.
  - Required: flush wins, pc_en=1, no stall, no DRAIN entry.
- RESET pulsed during DUMP at dump_addr=100.
  - Required: immediate IDLE, dump_en=0, dump_addr=0, done=0.
  - start after reset begins a fresh run with cycle_count=0.
- Force a run longer than 2^32 cycles (via force/preload): cycle_count saturates at 32'hFFFF_FFFF without wrapping.
